// File: rtl/ce_mac.sv
// ce_mac: multiply-accumulate custom engine.
// Decodes CEI ops in S, keeps a 40-bit accumulator and runs an iterative
// signed 16x16 multiply. Accumulator writes commit only once the issuing
// op has cleared M without an exception; a halt interlocks E meanwhile.
module ce_mac #(
  parameter logic [5:0]  MAC_OPC    = 6'h1C,
  parameter int unsigned RADIX_BITS = 4
) (
  input  logic        CLK,
  input  logic        RESET_D1_R_N,
  input  logic        CFG_CEENBL,
  input  logic        CEI_CEHOLD,
  input  logic        CEI_XCPN_M,
  input  logic [11:0] CEI_OP_S_R,
  input  logic        CEI_INSTM32_S_R_N,
  input  logic [31:0] CEI_AOP_E_R,
  output logic [31:0] MAC_RES_E,
  output logic        MAC_SEL_E_R,
  output logic        MAC_HALT_E_R_C
);

  localparam int unsigned N     = 16 / RADIX_BITS;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW    = 17 + RADIX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_WAIT
  } state_t;

  typedef enum logic [2:0] {
    SUB_MACZ = 3'd0,
    SUB_MAC  = 3'd1,
    SUB_MSU  = 3'd2,
    SUB_RDLO = 3'd3,
    SUB_RDHI = 3'd4,
    SUB_WRLO = 3'd5
  } sub_t;

  // E-stage register
  logic              r_e_vld;
  logic [2:0]        r_e_sub;

  // engine state
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_prod;
  logic [31:0]       r_opnd;
  logic [15:0]       r_mplier;
  logic [2:0]        r_op;
  logic              r_m_ok;
  logic [39:0]       r_acc;

  // decode / control
  logic              w_hit;
  logic              w_halt;
  logic              w_adv;
  logic              w_is_wr;
  logic              w_is_mul;
  logic              w_issue;
  logic              w_m_ok;
  logic              w_m_abort;
  logic              w_commit;
  logic              w_cnt_last;
  logic              w_is_rd;

  // multiply datapath
  logic [RADIX_BITS:0]   w_chunk;
  logic signed [PW-1:0]  w_mc_x;
  logic signed [PW-1:0]  w_ch_x;
  logic signed [PW-1:0]  w_pp;
  logic [31:0]           w_pp_ext;
  logic [31:0]           w_prod_nxt;
  logic [31:0]           w_prod_fin;
  logic [39:0]           w_prod40;
  logic [39:0]           w_acc_nxt;

  logic              w_unused_opbits;
  assign w_unused_opbits = ^CEI_OP_S_R[5:3];

  assign w_hit = !CFG_CEENBL && !CEI_INSTM32_S_R_N &&
                 (CEI_OP_S_R[11:6] == MAC_OPC) && (CEI_OP_S_R[2:0] <= 3'd5);

  assign w_halt    = r_e_vld && (r_state != ST_IDLE);
  assign w_adv     = !CEI_CEHOLD && !w_halt;
  assign w_is_mul  = (r_e_sub == SUB_MAC) || (r_e_sub == SUB_MSU);
  assign w_is_wr   = w_is_mul || (r_e_sub == SUB_MACZ) || (r_e_sub == SUB_WRLO);
  assign w_issue   = r_e_vld && w_adv && w_is_wr;
  assign w_is_rd   = (r_e_sub == SUB_RDLO) || (r_e_sub == SUB_RDHI);

  // M resolves in the first unheld cycle after issue; an exception there wins
  assign w_m_ok    = !CEI_CEHOLD && !CEI_XCPN_M;
  assign w_m_abort = !CEI_CEHOLD &&  CEI_XCPN_M;

  assign w_cnt_last = (r_cnt == CNT_W'(N - 1));

  // one radix digit of the multiplier times the multiplicand; top digit is signed
  always_comb begin
    w_chunk    = {w_cnt_last & r_mplier[RADIX_BITS-1], r_mplier[RADIX_BITS-1:0]};
    w_mc_x     = PW'($signed(r_opnd[31:16]));
    w_ch_x     = PW'($signed(w_chunk));
    w_pp       = w_mc_x * w_ch_x;
    w_pp_ext   = 32'(w_pp);
    w_prod_nxt = r_prod + (w_pp_ext << (32'(r_cnt) * RADIX_BITS));
  end

  // accumulator update value for the pending write op
  always_comb begin
    w_prod_fin = (r_state == ST_MUL) ? w_prod_nxt : r_prod;
    w_prod40   = {{8{w_prod_fin[31]}}, w_prod_fin};
    case (r_op)
      SUB_MACZ: w_acc_nxt = '0;
      SUB_MAC:  w_acc_nxt = r_acc + w_prod40;
      SUB_MSU:  w_acc_nxt = r_acc - w_prod40;
      default:  w_acc_nxt = {{8{r_opnd[31]}}, r_opnd};
    endcase
  end

  // FSM next state and commit decision
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) w_state_nxt = (w_is_mul) ? ST_MUL : ST_WAIT;
      end
      ST_MUL: begin
        if (!r_m_ok && w_m_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_cnt_last) begin
          if (r_m_ok || w_m_ok) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (w_m_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_m_ok) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) r_state <= ST_IDLE;
    else               r_state <= w_state_nxt;
  end

  // E-stage op register: exception flush beats the normal advance
  always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      r_e_vld <= 1'b0;
      r_e_sub <= '0;
    end else if (CEI_XCPN_M) begin
      r_e_vld <= 1'b0;
      r_e_sub <= '0;
    end else if (w_adv) begin
      r_e_vld <= w_hit;
      r_e_sub <= CEI_OP_S_R[2:0];
    end
  end

  // operand capture at issue and the iterative multiply; the counter ignores hold
  always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      r_op     <= '0;
      r_opnd   <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_m_ok   <= 1'b0;
    end else if (w_issue) begin
      r_op     <= r_e_sub;
      r_opnd   <= CEI_AOP_E_R;
      r_mplier <= CEI_AOP_E_R[15:0];
      r_prod   <= '0;
      r_cnt    <= '0;
      r_m_ok   <= 1'b0;
    end else if (r_state == ST_MUL) begin
      r_prod   <= w_prod_nxt;
      r_mplier <= r_mplier >> RADIX_BITS;
      if (!r_m_ok && w_m_ok) r_m_ok <= 1'b1;
      if (w_cnt_last || w_state_nxt == ST_IDLE) r_cnt <= '0;
      else                                      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // accumulator commit
  always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N)  r_acc <= '0;
    else if (w_commit)  r_acc <= w_acc_nxt;
  end

  assign MAC_HALT_E_R_C = w_halt;
  assign MAC_SEL_E_R    = r_e_vld && w_is_rd;
  assign MAC_RES_E      = !MAC_SEL_E_R ? '0 :
                          (r_e_sub == SUB_RDLO) ? r_acc[31:0] :
                          {{24{r_acc[39]}}, r_acc[39:32]};

endmodule
